// File: rtl/topdown_accumulator.sv
// Top-down cycle attribution: one cause per enabled cycle by static priority, with
// saturating live counters, snapshot-and-clear shadows and a registered read port.
// Optional sum-check on snapshot is enabled by defining TOPDOWN_SUM_CHECK_EN.
module topdown_accumulator #(
   parameter int unsigned         N_CAUSES         = 6,
   parameter int unsigned         CNT_W            = 32,
   parameter logic [N_CAUSES-1:0] FIRST_CYCLE_MASK = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          en_i,
   input  logic [N_CAUSES-1:0]           cause_i,
   input  logic                          snap_i,
   input  logic                          clr_i,
   input  logic [$clog2(N_CAUSES+1)-1:0] rd_idx_i,
   output logic [CNT_W-1:0]              rd_data_o,
   output logic                          rd_ovf_o,
   output logic [N_CAUSES-1:0]           attr_o,
   output logic                          err_o
);

   localparam int unsigned      IDX_W   = $clog2(N_CAUSES+1);
   localparam logic [IDX_W-1:0] TOT_IDX = IDX_W'(N_CAUSES);

   // Catch-all raw bit never competes, so it needs no edge register.
   logic                  unused_catchall;
   logic [N_CAUSES-2:0]   prev_q, prev_d;
   logic [N_CAUSES-2:0]   qual;
   logic [N_CAUSES-1:0]   win_oh;
   logic                  found;
   logic [N_CAUSES:0]     inc;
   logic [N_CAUSES-1:0]   attr_q, attr_d;

   // Entry N_CAUSES of each array holds the total-cycle counter.
   logic [N_CAUSES:0][CNT_W-1:0] live_q, live_d;
   logic [N_CAUSES:0][CNT_W-1:0] shadow_q, shadow_d;
   logic [N_CAUSES:0]            ovf_q, ovf_d;
   logic [N_CAUSES:0]            shovf_q, shovf_d;

   logic [CNT_W-1:0]      rd_data_q, rd_data_d;
   logic                  rd_ovf_q, rd_ovf_d;

   assign unused_catchall = cause_i[N_CAUSES-1];

   always_comb begin
      prev_d = cause_i[N_CAUSES-2:0];
      qual   = cause_i[N_CAUSES-2:0] &
               ~(FIRST_CYCLE_MASK[N_CAUSES-2:0] & prev_q);
      win_oh = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < N_CAUSES-1; i++) begin
         if (qual[i] && !found) begin
            win_oh[i] = 1'b1;
            found     = 1'b1;
         end
      end
      if (!found) begin
         win_oh[N_CAUSES-1] = 1'b1;
      end
      inc    = {en_i, win_oh & {N_CAUSES{en_i}}};
      attr_d = inc[N_CAUSES-1:0];
   end

   always_comb begin
      live_d   = live_q;
      ovf_d    = ovf_q;
      shadow_d = shadow_q;
      shovf_d  = shovf_q;
      if (clr_i) begin
         live_d = '0;
         ovf_d  = '0;
      end else if (snap_i) begin
         // Shadows take the pre-increment value; live restarts from this cycle's increment.
         shadow_d = live_q;
         shovf_d  = ovf_q;
         ovf_d    = '0;
         for (int unsigned k = 0; k <= N_CAUSES; k++) begin
            live_d[k] = CNT_W'(inc[k]);
         end
      end else begin
         for (int unsigned k = 0; k <= N_CAUSES; k++) begin
            if (inc[k]) begin
               if (&live_q[k]) begin
                  ovf_d[k] = 1'b1;
               end else begin
                  live_d[k] = live_q[k] + CNT_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      rd_data_d = '0;
      rd_ovf_d  = 1'b0;
      if (rd_idx_i <= TOT_IDX) begin
         rd_data_d = shadow_q[rd_idx_i];
         rd_ovf_d  = shovf_q[rd_idx_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q    <= '0;
         attr_q    <= '0;
         live_q    <= '0;
         ovf_q     <= '0;
         shadow_q  <= '0;
         shovf_q   <= '0;
         rd_data_q <= '0;
         rd_ovf_q  <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         attr_q    <= attr_d;
         live_q    <= live_d;
         ovf_q     <= ovf_d;
         shadow_q  <= shadow_d;
         shovf_q   <= shovf_d;
         rd_data_q <= rd_data_d;
         rd_ovf_q  <= rd_ovf_d;
      end
   end

   assign rd_data_o = rd_data_q;
   assign rd_ovf_o  = rd_ovf_q;
   assign attr_o    = attr_q;

`ifdef TOPDOWN_SUM_CHECK_EN
   localparam int unsigned SUM_W = CNT_W + $clog2(N_CAUSES);

   logic [SUM_W-1:0] cause_sum;
   logic             err_q, err_d;

   always_comb begin
      cause_sum = '0;
      for (int unsigned k = 0; k < N_CAUSES; k++) begin
         cause_sum = cause_sum + SUM_W'(live_q[k]);
      end
      err_d = err_q;
      if (clr_i) begin
         err_d = 1'b0;
      end else if (snap_i && !(|ovf_q) && (cause_sum != SUM_W'(live_q[N_CAUSES]))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_topdown_accumulator.sv
// Directed bench for topdown_accumulator: N_CAUSES=6, CNT_W=8, first-cycle filter on cause 0.
module tb_topdown_accumulator;

   logic       clk;
   logic       rst_ni;
   logic       en_i;
   logic [5:0] cause_i;
   logic       snap_i;
   logic       clr_i;
   logic [2:0] rd_idx_i;
   logic [7:0] rd_data_o;
   logic       rd_ovf_o;
   logic [5:0] attr_o;
   logic       err_o;

   int n_cmp = 0;
   int n_bad = 0;

   topdown_accumulator #(
      .N_CAUSES        (6),
      .CNT_W           (8),
      .FIRST_CYCLE_MASK(6'b000001)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .en_i     (en_i),
      .cause_i  (cause_i),
      .snap_i   (snap_i),
      .clr_i    (clr_i),
      .rd_idx_i (rd_idx_i),
      .rd_data_o(rd_data_o),
      .rd_ovf_o (rd_ovf_o),
      .attr_o   (attr_o),
      .err_o    (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int idx, output logic [7:0] d, output logic o);
      en_i     = 1'b0;
      cause_i  = '0;
      rd_idx_i = 3'(idx);
      tick();
      d = rd_data_o;
      o = rd_ovf_o;
   endtask

   task automatic do_snap;
      en_i    = 1'b0;
      cause_i = '0;
      snap_i  = 1'b1;
      tick();
      snap_i  = 1'b0;
   endtask

   task automatic test_reset;
      logic [7:0] d;
      logic       o;
      rst_ni = 1'b0; en_i = 1'b0; cause_i = '0; snap_i = 1'b0; clr_i = 1'b0; rd_idx_i = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (rd_data_o !== 8'd0 || rd_ovf_o !== 1'b0 || attr_o !== 6'd0 || err_o !== 1'b0) begin
         $display("FAIL reset_out got d=%0d o=%b a=%b e=%b want 0/0/000000/0",
                  rd_data_o, rd_ovf_o, attr_o, err_o);
         n_bad++;
      end
      rst_ni = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         rd(i, d, o);
         n_cmp++;
         if (d !== 8'd0 || o !== 1'b0) begin
            $display("FAIL reset_rd idx=%0d got %0d/%b want 0/0", i, d, o);
            n_bad++;
         end
      end
   endtask

   task automatic test_priority;
      logic [7:0] d;
      logic       o;
      int         exp_d[8] = '{0, 10, 0, 0, 0, 0, 10, 0};
      en_i = 1'b1; cause_i = 6'b001110;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_cmp++;
         if (attr_o !== 6'b000010) begin
            $display("FAIL prio_attr cyc=%0d got %b want 000010", c, attr_o);
            n_bad++;
         end
      end
      do_snap();
      n_cmp++;
      if (attr_o !== 6'b000000) begin
         $display("FAIL prio_attr_off got %b want 000000", attr_o);
         n_bad++;
      end
      for (int i = 0; i < 8; i++) begin
         rd(i, d, o);
         n_cmp++;
         if (d !== 8'(exp_d[i]) || o !== 1'b0) begin
            $display("FAIL prio_rd idx=%0d got %0d/%b want %0d/0", i, d, o, exp_d[i]);
            n_bad++;
         end
      end
   endtask

   task automatic test_catchall;
      logic [7:0] d;
      logic       o;
      int         exp_d[8] = '{0, 0, 0, 0, 0, 7, 7, 0};
      en_i = 1'b1; cause_i = 6'b000000;
      for (int c = 0; c < 7; c++) begin
         tick();
         n_cmp++;
         if (attr_o !== 6'b100000) begin
            $display("FAIL catch_attr cyc=%0d got %b want 100000", c, attr_o);
            n_bad++;
         end
      end
      do_snap();
      for (int i = 0; i < 8; i++) begin
         rd(i, d, o);
         n_cmp++;
         if (d !== 8'(exp_d[i]) || o !== 1'b0) begin
            $display("FAIL catch_rd idx=%0d got %0d/%b want %0d/0", i, d, o, exp_d[i]);
            n_bad++;
         end
      end
      n_cmp++;
      if (err_o !== 1'b0) begin
         $display("FAIL catch_err got %b want 0", err_o);
         n_bad++;
      end
   endtask

   task automatic test_first_cycle;
      logic [7:0] d;
      logic       o;
      int         exp_d[8] = '{1, 0, 0, 0, 0, 4, 5, 0};
      en_i = 1'b1; cause_i = 6'b000001;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if (attr_o !== ((c == 0) ? 6'b000001 : 6'b100000)) begin
            $display("FAIL first_attr cyc=%0d got %b want %b", c, attr_o,
                     (c == 0) ? 6'b000001 : 6'b100000);
            n_bad++;
         end
      end
      do_snap();
      for (int i = 0; i < 8; i++) begin
         rd(i, d, o);
         n_cmp++;
         if (d !== 8'(exp_d[i]) || o !== 1'b0) begin
            $display("FAIL first_rd idx=%0d got %0d/%b want %0d/0", i, d, o, exp_d[i]);
            n_bad++;
         end
      end
   endtask

   task automatic test_enable_off;
      logic [7:0] d;
      logic       o;
      en_i = 1'b0; cause_i = 6'b000010;
      repeat (3) tick();
      n_cmp++;
      if (attr_o !== 6'b000000) begin
         $display("FAIL en_off_attr got %b want 000000", attr_o);
         n_bad++;
      end
      do_snap();
      rd(1, d, o);
      n_cmp++;
      if (d !== 8'd0) begin
         $display("FAIL en_off_rd1 got %0d want 0", d);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd0) begin
         $display("FAIL en_off_tot got %0d want 0", d);
         n_bad++;
      end
   endtask

   task automatic test_saturation;
      logic [7:0] d;
      logic       o;
      // Exactly at the maximum: no overflow yet.
      en_i = 1'b1; cause_i = 6'b000100;
      repeat (255) tick();
      do_snap();
      rd(2, d, o);
      n_cmp++;
      if (d !== 8'd255 || o !== 1'b0) begin
         $display("FAIL sat255_c2 got %0d/%b want 255/0", d, o);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd255 || o !== 1'b0) begin
         $display("FAIL sat255_tot got %0d/%b want 255/0", d, o);
         n_bad++;
      end
      en_i = 1'b1; cause_i = 6'b000100;
      repeat (300) tick();
      do_snap();
      rd(2, d, o);
      n_cmp++;
      if (d !== 8'd255 || o !== 1'b1) begin
         $display("FAIL sat300_c2 got %0d/%b want 255/1", d, o);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd255 || o !== 1'b1) begin
         $display("FAIL sat300_tot got %0d/%b want 255/1", d, o);
         n_bad++;
      end
      rd(0, d, o);
      n_cmp++;
      if (d !== 8'd0 || o !== 1'b0) begin
         $display("FAIL sat300_c0 got %0d/%b want 0/0", d, o);
         n_bad++;
      end
      do_snap();
      rd(2, d, o);
      n_cmp++;
      if (d !== 8'd0 || o !== 1'b0) begin
         $display("FAIL sat_reclear got %0d/%b want 0/0", d, o);
         n_bad++;
      end
   endtask

   task automatic test_snap_collision;
      logic [7:0] d;
      logic       o;
      en_i = 1'b1; cause_i = 6'b001000;
      repeat (4) tick();
      snap_i = 1'b1;
      tick();
      snap_i = 1'b0;
      rd(3, d, o);
      n_cmp++;
      if (d !== 8'd4) begin
         $display("FAIL coll_shadow got %0d want 4", d);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd4) begin
         $display("FAIL coll_shadow_tot got %0d want 4", d);
         n_bad++;
      end
      // Read in the snapshot cycle sees the old shadow.
      rd_idx_i = 3'd3;
      do_snap();
      n_cmp++;
      if (rd_data_o !== 8'd4) begin
         $display("FAIL snap_rd_old got %0d want 4", rd_data_o);
         n_bad++;
      end
      rd(3, d, o);
      n_cmp++;
      if (d !== 8'd1) begin
         $display("FAIL coll_live got %0d want 1", d);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd1) begin
         $display("FAIL coll_live_tot got %0d want 1", d);
         n_bad++;
      end
   endtask

   task automatic test_snap_clr;
      logic [7:0] d;
      logic       o;
      en_i = 1'b1; cause_i = 6'b001000;
      repeat (2) tick();
      snap_i = 1'b1; clr_i = 1'b1;
      tick();
      snap_i = 1'b0; clr_i = 1'b0;
      rd(3, d, o);
      n_cmp++;
      if (d !== 8'd1) begin
         $display("FAIL snapclr_shadow got %0d want 1", d);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd1) begin
         $display("FAIL snapclr_shadow_tot got %0d want 1", d);
         n_bad++;
      end
      do_snap();
      rd(3, d, o);
      n_cmp++;
      if (d !== 8'd0) begin
         $display("FAIL snapclr_live got %0d want 0", d);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd0) begin
         $display("FAIL snapclr_live_tot got %0d want 0", d);
         n_bad++;
      end
      en_i = 1'b1; cause_i = 6'b001000;
      repeat (3) tick();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      repeat (2) tick();
      do_snap();
      rd(3, d, o);
      n_cmp++;
      if (d !== 8'd2) begin
         $display("FAIL clr_then_count got %0d want 2", d);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd2 || err_o !== 1'b0) begin
         $display("FAIL clr_then_count_tot got %0d err=%b want 2 err=0", d, err_o);
         n_bad++;
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] d;
      logic       o;
      en_i = 1'b1; cause_i = 6'b000010;
      repeat (20) tick();
      do_snap();
      rd(1, d, o);
      n_cmp++;
      if (d !== 8'd20) begin
         $display("FAIL pre_reset_rd got %0d want 20", d);
         n_bad++;
      end
      en_i = 1'b1; cause_i = 6'b000010;
      repeat (5) tick();
      rst_ni = 1'b0;
      #2;
      n_cmp++;
      if (rd_data_o !== 8'd0 || rd_ovf_o !== 1'b0 || attr_o !== 6'd0 || err_o !== 1'b0) begin
         $display("FAIL mid_reset_out got d=%0d o=%b a=%b e=%b want 0/0/000000/0",
                  rd_data_o, rd_ovf_o, attr_o, err_o);
         n_bad++;
      end
      en_i = 1'b0; cause_i = '0;
      rst_ni = 1'b1;
      rd(1, d, o);
      n_cmp++;
      if (d !== 8'd0 || o !== 1'b0) begin
         $display("FAIL post_reset_rd got %0d/%b want 0/0", d, o);
         n_bad++;
      end
      en_i = 1'b1; cause_i = 6'b000010;
      repeat (3) tick();
      do_snap();
      rd(1, d, o);
      n_cmp++;
      if (d !== 8'd3) begin
         $display("FAIL post_reset_snap got %0d want 3", d);
         n_bad++;
      end
      rd(6, d, o);
      n_cmp++;
      if (d !== 8'd3) begin
         $display("FAIL post_reset_tot got %0d want 3", d);
         n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_catchall();
      test_first_cycle();
      test_enable_off();
      test_saturation();
      test_snap_collision();
      test_snap_clr();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
